pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central pipeline sequencer for the five-stage ARM core. It generates the `ready`, `flush` and freeze controls that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers consume. It does this by arbitrating between three causes:

- data-cache/SRAM wait states
- taken-branch flushes
- load-use (or no-forwarding) data hazards

It also keeps saturating stall and flush performance counters.

## Interface

Parameters:

- `CNT_W`, default 16: width of the performance counters.

Ports:

- `clk`, input, 1: core clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `fwd_en`, input, 1: forwarding unit enabled.
- `id_src1`, input, 4: ID-stage Rn index.
- `id_src2`, input, 4: ID-stage Rm/Rd index.
- `id_use_src1`, input, 1: ID-stage instruction reads `id_src1`.
- `id_use_src2`, input, 1: ID-stage instruction reads `id_src2`.
- `exe_wb_en`, input, 1: ID/EX register output write-back enable.
- `exe_mem_r_en`, input, 1: ID/EX register output load flag.
- `exe_dest`, input, 4: ID/EX register output destination.
- `mem_wb_en`, input, 1: EX/MEM register write-back enable.
- `mem_dest`, input, 4: EX/MEM register destination.
- `branch_taken`, input, 1: branch resolved taken in EXE.
- `mem_req`, input, 1: MEM-stage instruction issues a read or write.
- `mem_ready`, input, 1: cache/SRAM controller completes the current access.
- `cnt_clr`, input, 1: synchronous clear of both counters.
- `pipe_ready`, output, 1: advance enable for all pipeline registers.
- `freeze_if`, output, 1: hold the PC.
- `freeze_id`, output, 1: hold the IF/ID register.
- `flush_if_id`, output, 1: bubble IF/ID.
- `flush_id_ex`, output, 1: bubble ID/EX.
- `stall_cnt`, output, `CNT_W`: cycles lost to memory waits or hazards.
- `flush_cnt`, output, `CNT_W`: taken-branch flush events.

## Operation

**Memory FSM.** Three states: IDLE, WAIT, RELEASE.

- IDLE:
  - `mem_req`=1 and `mem_ready`=1: hit; stay in IDLE with `pipe_ready`=1.
  - `mem_req`=1 and `mem_ready`=0: go to WAIT with `pipe_ready`=0 this cycle.
- WAIT:
  - `pipe_ready`=0.
  - `mem_ready`=1 moves to RELEASE.
  - `mem_req` is ignored.
- RELEASE:
  - `pipe_ready`=1 for exactly one cycle, then go to IDLE.
  - `mem_req` is ignored, because the same instruction is still in MEM.

**Hazard detect.** Combinational; `hazard` is the OR of these matches:

- Load-use: `exe_wb_en` & `exe_mem_r_en` & `exe_dest` equal to a used source (`id_src1` with `id_use_src1`, or `id_src2` with `id_use_src2`).
- When `fwd_en`=0, additionally:
  - `exe_wb_en` & `exe_dest` matches a used source.
  - `mem_wb_en` & `mem_dest` matches a used source.

**Output priority.** All outputs are combinational from state and inputs:

- If `pipe_ready`=0, then `flush_if_id`=`flush_id_ex`=`freeze_if`=`freeze_id`=0. Branches and hazards are deferred, not lost: the inputs remain valid because the registers are frozen.
- Else if `branch_taken`, then `flush_if_id`=`flush_id_ex`=1 and freezes stay 0. A hazard in the same cycle is ignored, since the instruction in ID is discarded.
- Else if `hazard`, then `freeze_if`=`freeze_id`=`flush_id_ex`=1, inserting one bubble per hazard cycle.
- Otherwise all controls are 0.

**Counters.**

- `stall_cnt` increments on each cycle where `pipe_ready`=0, or where `hazard`=1 and `branch_taken`=0.
- `flush_cnt` increments on each cycle where `pipe_ready`=1 and `branch_taken`=1.
- Both saturate at all-ones and never wrap.
- `cnt_clr` has priority over increment; a clear in the same cycle as an increment yields 0.

## Timing

- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE; `stall_cnt`=`flush_cnt`=0.
  - While `rst`=0, `pipe_ready`=1 and all flush/freeze outputs are forced to 0.
  - Reset asserted during WAIT aborts the wait; the first cycle after reset is IDLE.
- Cache miss: `pipe_ready` falls in the same cycle as `mem_req` with `mem_ready`=0. It rises in the cycle after the one in which `mem_ready` is first 1.
  - An N-cycle miss (`mem_ready` high in the N-th WAIT cycle) gives N+1 cycles of `pipe_ready`=0.
- Zero extra latency on a hit.
- Flush and freeze are zero-latency combinational. The pipeline registers act on them at the next rising edge.
- Counter outputs update one cycle after the qualifying cycle.

## Test plan

- **Reset mid-wait:** enter WAIT, pull `rst` low, release → IDLE, `pipe_ready`=1, both counters 0.
- **Hit and miss:**
  - `mem_req`=1 with `mem_ready`=1 → `pipe_ready` never drops.
  - `mem_req`=1 with `mem_ready` low for 3 cycles, then high → `pipe_ready`=0 for 4 cycles, `stall_cnt`=4.
- **Load-use:** `exe_mem_r_en`=`exe_wb_en`=1, `exe_dest`=5, `id_src1`=5, `id_use_src1`=1, `fwd_en`=1 → `freeze_if`=`freeze_id`=`flush_id_ex`=1. Same case with `exe_mem_r_en`=0 → no hazard.
- **No forwarding:** `fwd_en`=0, `mem_wb_en`=1, `mem_dest`=3, `id_src2`=3, `id_use_src2`=1 → hazard. Same case with `id_use_src2`=0 → no hazard.
- **Branch vs hazard:** `branch_taken`=1 with a simultaneous load-use hazard → both flushes =1, freezes =0, `flush_cnt`+1, `stall_cnt` unchanged.
- **Branch during miss, and saturation:**
  - `branch_taken`=1 during WAIT → no flush until the RELEASE cycle, then one flush and `flush_cnt`=1.
  - Preload `stall_cnt` to within 2 of max and hold a miss for 5 cycles → value holds at all-ones.
  - `cnt_clr` during an increment → 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: arbitrates memory wait states, taken-branch flushes and data hazards
// into ready/flush/freeze controls, and keeps saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pipe_ready,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StRelease} state_e;

  state_e           state_q, state_d;
  logic             ready;
  logic             ctrl_en;
  logic             exe_hit, mem_hit, hazard;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign exe_hit = (id_use_src1 && (id_src1 == exe_dest)) ||
                   (id_use_src2 && (id_src2 == exe_dest));
  assign mem_hit = (id_use_src1 && (id_src1 == mem_dest)) ||
                   (id_use_src2 && (id_src2 == mem_dest));

  // Without forwarding any in-flight writer of a source stalls, not just a load.
  assign hazard = (exe_wb_en && exe_hit && (exe_mem_r_en || !fwd_en)) ||
                  (!fwd_en && mem_wb_en && mem_hit);

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (mem_req && !mem_ready) begin
          ready   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        ready = 1'b0;
        if (mem_ready) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Controls are forced to their idle values while reset is held.
  assign ctrl_en     = rst && ready;
  assign pipe_ready  = ready || !rst;
  assign flush_if_id = ctrl_en && branch_taken;
  assign flush_id_ex = ctrl_en && (branch_taken || hazard);
  assign freeze_if   = ctrl_en && !branch_taken && hazard;
  assign freeze_id   = freeze_if;

  assign stall_inc = !ready || (hazard && !branch_taken);
  assign flush_inc = ready && branch_taken;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
